// File: rtl/multi_channel_edge_pulse_gen.sv
// multi_channel_edge_pulse_gen
// WIDTH independent channels, each turning level transitions on data_in into a
// registered pulse of PULSE_LEN cycles. Edge polarity is selected at runtime,
// the input may be synchronised, and per-channel sticky event/overrun status
// is kept until cleared.
module multi_channel_edge_pulse_gen #(
    parameter int WIDTH       = 8,
    parameter int PULSE_LEN   = 1,
    parameter int SYNC_STAGES = 2,
    parameter int RETRIGGER   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       edge_mode,
    input  logic [WIDTH-1:0] sticky_clr,
    output logic [WIDTH-1:0] pulse,
    output logic [WIDTH-1:0] busy,
    output logic [WIDTH-1:0] event_sticky,
    output logic [WIDTH-1:0] overrun
);

    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam int WW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PULSE_LEN - 1);
    localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;
    logic [WW-1:0]    warm_q;
    logic             warm_ok;

    // Optional synchroniser chain; with zero stages data_in is used directly.
    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

        // Shift data_in through SYNC_STAGES flops per channel.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= data_in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign s = data_in;
    end

    // Previous synchronised level; tracks s in every edge_mode so that a mode
    // change never fabricates an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= s;
    end

    // Warm-up: hold off detection until the sync chain and prev hold real data,
    // so a level already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  warm_q <= '0;
        else if (warm_q != WARM_DONE) warm_q <= warm_q + WW'(1);
    end

    assign warm_ok = (warm_q == WARM_DONE);
    assign rise    = s & ~prev;
    assign fall    = ~s & prev;

    // Select which transitions count as edges; mode 11 blocks all new edges.
    always_comb begin
        edge_sel = '0;
        case (edge_mode)
            MODE_RISE: edge_sel = rise;
            MODE_FALL: edge_sel = fall;
            MODE_BOTH: edge_sel = rise | fall;
            default:   edge_sel = '0;
        endcase
        if (!warm_ok) edge_sel = '0;
    end

    // Per-channel pulse FSM and status.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [0:0]    state_q;
        logic [CW-1:0] cnt_q;
        logic          evt_q;
        logic          ovr_q;
        logic          at_last;
        logic          take;
        logic          drop;

        assign at_last = (cnt_q == CNT_LAST);

        // An edge is accepted from IDLE, on the last pulse cycle (back-to-back),
        // or anywhere in the pulse when retriggering; otherwise it is dropped.
        always_comb begin
            take = 1'b0;
            drop = 1'b0;
            if (edge_sel[i]) begin
                if (state_q == ST_IDLE || at_last || RETRIGGER != 0) take = 1'b1;
                else                                                drop = 1'b1;
            end
        end

        // IDLE/ACTIVE sequencing with the pulse-length counter.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (take) begin
                            state_q <= ST_ACTIVE;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        if (take) begin
                            cnt_q <= '0;
                        end else if (at_last) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                endcase
            end
        end

        // Sticky status: a set in the same cycle as a clear wins.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                evt_q <= 1'b0;
                ovr_q <= 1'b0;
            end else begin
                if (take)               evt_q <= 1'b1;
                else if (sticky_clr[i]) evt_q <= 1'b0;
                if (drop)               ovr_q <= 1'b1;
                else if (sticky_clr[i]) ovr_q <= 1'b0;
            end
        end

        assign pulse[i]        = (state_q == ST_ACTIVE);
        assign busy[i]         = (state_q == ST_ACTIVE);
        assign event_sticky[i] = evt_q;
        assign overrun[i]      = ovr_q;
    end

endmodule

// File: tb/tb_multi_channel_edge_pulse_gen.sv
// Directed bench for multi_channel_edge_pulse_gen. Four instances cover the
// parameter combinations: a (len 1, no sync), b (len 4, drop), c (len 4,
// retrigger), d (len 3, 2-stage sync). Outputs are sampled on the falling edge.
module tb_multi_channel_edge_pulse_gen;

    logic clk;
    logic reset;

    logic [3:0] a_data, a_clr, a_pulse, a_busy, a_evt, a_ovr;
    logic [3:0] b_data, b_clr, b_pulse, b_busy, b_evt, b_ovr;
    logic [3:0] c_data, c_clr, c_pulse, c_busy, c_evt, c_ovr;
    logic [3:0] d_data, d_clr, d_pulse, d_busy, d_evt, d_ovr;
    logic [1:0] a_mode, b_mode, c_mode, d_mode;

    int checks = 0;
    int errors = 0;

    multi_channel_edge_pulse_gen #(.WIDTH(4), .PULSE_LEN(1), .SYNC_STAGES(0), .RETRIGGER(0)) dut_a (
        .clk(clk), .reset(reset), .data_in(a_data), .edge_mode(a_mode), .sticky_clr(a_clr),
        .pulse(a_pulse), .busy(a_busy), .event_sticky(a_evt), .overrun(a_ovr));

    multi_channel_edge_pulse_gen #(.WIDTH(4), .PULSE_LEN(4), .SYNC_STAGES(0), .RETRIGGER(0)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_data), .edge_mode(b_mode), .sticky_clr(b_clr),
        .pulse(b_pulse), .busy(b_busy), .event_sticky(b_evt), .overrun(b_ovr));

    multi_channel_edge_pulse_gen #(.WIDTH(4), .PULSE_LEN(4), .SYNC_STAGES(0), .RETRIGGER(1)) dut_c (
        .clk(clk), .reset(reset), .data_in(c_data), .edge_mode(c_mode), .sticky_clr(c_clr),
        .pulse(c_pulse), .busy(c_busy), .event_sticky(c_evt), .overrun(c_ovr));

    multi_channel_edge_pulse_gen #(.WIDTH(4), .PULSE_LEN(3), .SYNC_STAGES(2), .RETRIGGER(0)) dut_d (
        .clk(clk), .reset(reset), .data_in(d_data), .edge_mode(d_mode), .sticky_clr(d_clr),
        .pulse(d_pulse), .busy(d_busy), .event_sticky(d_evt), .overrun(d_ovr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({a_pulse, a_busy, a_evt, a_ovr} !== 16'h0) begin
            errors++; $display("FAIL reset_a: got %h expected 0000", {a_pulse, a_busy, a_evt, a_ovr});
        end
        checks++;
        if ({b_pulse, b_busy, b_evt, b_ovr} !== 16'h0) begin
            errors++; $display("FAIL reset_b: got %h expected 0000", {b_pulse, b_busy, b_evt, b_ovr});
        end
        checks++;
        if ({c_pulse, c_busy, c_evt, c_ovr} !== 16'h0) begin
            errors++; $display("FAIL reset_c: got %h expected 0000", {c_pulse, c_busy, c_evt, c_ovr});
        end
        checks++;
        if ({d_pulse, d_busy, d_evt, d_ovr} !== 16'h0) begin
            errors++; $display("FAIL reset_d: got %h expected 0000", {d_pulse, d_busy, d_evt, d_ovr});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Rising mode, len 1: one 1-cycle pulse one cycle after the rise, none on fall.
    task automatic test_single_pulse();
        logic [9:0] h;
        logic [4:0] h2;
        logic       other;
        h = '0; h2 = '0; other = 1'b0;
        @(negedge clk);
        a_data[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            h[k] = a_pulse[0];
            other = other | (|a_pulse[3:1]);
        end
        a_data[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            h2[k] = a_pulse[0];
        end
        checks++;
        if (h !== 10'b0000000001) begin
            errors++; $display("FAIL single_rise: got %b expected 0000000001", h);
        end
        checks++;
        if (h2 !== 5'b00000) begin
            errors++; $display("FAIL single_fall_ignored: got %b expected 00000", h2);
        end
        checks++;
        if (other !== 1'b0) begin
            errors++; $display("FAIL single_other_ch: got %b expected 0", other);
        end
        checks++;
        if (a_evt !== 4'b0001) begin
            errors++; $display("FAIL single_sticky: got %b expected 0001", a_evt);
        end
    endtask

    // Falling mode: rise is ignored, fall produces the pulse.
    task automatic test_falling_mode();
        logic [3:0] hr, hf;
        hr = '0; hf = '0;
        @(negedge clk);
        a_mode = 2'b01;
        @(negedge clk);
        a_data[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hr[k] = a_pulse[3];
        end
        a_data[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hf[k] = a_pulse[3];
        end
        a_mode = 2'b00;
        checks++;
        if (hr !== 4'b0000) begin
            errors++; $display("FAIL falling_rise_ignored: got %b expected 0000", hr);
        end
        checks++;
        if (hf !== 4'b0001) begin
            errors++; $display("FAIL falling_pulse: got %b expected 0001", hf);
        end
    endtask

    // Both edges, len 3, 2-stage sync: pulse starts 3 samples after each change.
    task automatic test_both_edges();
        logic [9:0] hr, hf;
        hr = '0; hf = '0;
        @(negedge clk);
        d_data[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hr[k] = d_pulse[1];
        end
        d_data[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hf[k] = d_pulse[1];
        end
        checks++;
        if (hr !== 10'b0000011100) begin
            errors++; $display("FAIL both_rise: got %b expected 0000011100", hr);
        end
        checks++;
        if (hf !== 10'b0000011100) begin
            errors++; $display("FAIL both_fall: got %b expected 0000011100", hf);
        end
    endtask

    // Second edge two cycles into a 4-cycle pulse: dropped (b) vs reloaded (c).
    task automatic test_retrigger();
        logic [11:0] hb, hc;
        hb = '0; hc = '0;
        @(negedge clk);
        b_data[2] = 1'b1;
        c_data[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            hb[k] = b_pulse[2];
            hc[k] = c_pulse[2];
            if (k == 1) begin
                b_data[2] = 1'b0;
                c_data[2] = 1'b0;
            end
        end
        checks++;
        if (hb !== 12'h00F) begin
            errors++; $display("FAIL retrig0_width: got %b expected 000000001111", hb);
        end
        checks++;
        if (b_ovr[2] !== 1'b1) begin
            errors++; $display("FAIL retrig0_overrun: got %b expected 1", b_ovr[2]);
        end
        checks++;
        if (hc !== 12'h03F) begin
            errors++; $display("FAIL retrig1_width: got %b expected 000000111111", hc);
        end
        checks++;
        if (c_ovr[2] !== 1'b0) begin
            errors++; $display("FAIL retrig1_overrun: got %b expected 0", c_ovr[2]);
        end
    endtask

    // Edges landing on the last pulse cycle chain pulses with no gap.
    task automatic test_back_to_back();
        logic [5:0] ha;
        logic [9:0] hb;
        ha = '0; hb = '0;
        @(negedge clk);
        a_mode = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) a_data[2] = ~a_data[2];
            @(negedge clk);
            ha[k] = a_pulse[2];
        end
        a_mode = 2'b00;
        checks++;
        if (ha !== 6'b001111) begin
            errors++; $display("FAIL b2b_len1: got %b expected 001111", ha);
        end
        checks++;
        if (a_ovr[2] !== 1'b0) begin
            errors++; $display("FAIL b2b_len1_overrun: got %b expected 0", a_ovr[2]);
        end
        b_data[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hb[k] = b_pulse[3];
            if (k == 3) b_data[3] = 1'b0;
        end
        checks++;
        if (hb !== 10'b0011111111) begin
            errors++; $display("FAIL b2b_len4: got %b expected 0011111111", hb);
        end
        checks++;
        if (b_ovr[3] !== 1'b0) begin
            errors++; $display("FAIL b2b_len4_overrun: got %b expected 0", b_ovr[3]);
        end
    endtask

    // Simultaneous rises on all channels are all accepted.
    task automatic test_channels();
        @(negedge clk);
        a_data = 4'hF;
        @(negedge clk);
        checks++;
        if (a_pulse !== 4'hF) begin
            errors++; $display("FAIL all_channels: got %b expected 1111", a_pulse);
        end
        @(negedge clk);
        checks++;
        if (a_pulse !== 4'h0) begin
            errors++; $display("FAIL all_channels_end: got %b expected 0000", a_pulse);
        end
        a_data = 4'h0;
        @(negedge clk);
    endtask

    // Clear alone clears; clear together with a new edge loses to the set.
    task automatic test_sticky();
        @(negedge clk);
        a_clr[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (a_evt[0] !== 1'b0) begin
            errors++; $display("FAIL sticky_clear: got %b expected 0", a_evt[0]);
        end
        a_data[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (a_evt[0] !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins: got %b expected 1", a_evt[0]);
        end
        checks++;
        if (a_pulse[0] !== 1'b1) begin
            errors++; $display("FAIL sticky_clr_pulse: got %b expected 1", a_pulse[0]);
        end
        @(negedge clk);
        checks++;
        if (a_evt[0] !== 1'b0) begin
            errors++; $display("FAIL sticky_clear_after: got %b expected 0", a_evt[0]);
        end
        a_clr[0] = 1'b0;
        a_data[0] = 1'b0;
        b_clr[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ovr[2] !== 1'b0) begin
            errors++; $display("FAIL overrun_clear: got %b expected 0", b_ovr[2]);
        end
        b_clr[2] = 1'b0;
    endtask

    // Mode 11 during a 4-cycle pulse: it completes, new edges ignored.
    task automatic test_disable();
        logic [9:0] h0, h1;
        logic [3:0] hr;
        h0 = '0; h1 = '0; hr = '0;
        @(negedge clk);
        b_data[0] = 1'b1;
        @(negedge clk);
        h0[0] = b_pulse[0];
        h1[0] = b_pulse[1];
        b_mode = 2'b11;
        b_data[1] = 1'b1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            h0[k] = b_pulse[0];
            h1[k] = b_pulse[1];
            if (k == 2) b_data[0] = 1'b0;
            if (k == 4) b_data[1] = 1'b0;
            if (k == 6) b_data[1] = 1'b1;
        end
        checks++;
        if (h0 !== 10'b0000001111) begin
            errors++; $display("FAIL disable_finish: got %b expected 0000001111", h0);
        end
        checks++;
        if (h1 !== 10'b0000000000) begin
            errors++; $display("FAIL disable_no_new: got %b expected 0000000000", h1);
        end
        checks++;
        if ({b_ovr[1:0], b_evt[1]} !== 3'b000) begin
            errors++; $display("FAIL disable_status: got %b expected 000", {b_ovr[1:0], b_evt[1]});
        end
        b_mode = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hr[k] = b_pulse[1];
        end
        checks++;
        if (hr !== 4'b0000) begin
            errors++; $display("FAIL mode_change_no_edge: got %b expected 0000", hr);
        end
        b_data[1] = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Level held high through reset release gives no pulse; reset cuts a pulse at once.
    task automatic test_warmup_and_async_reset();
        logic any_pulse;
        any_pulse = 1'b0;
        @(negedge clk);
        d_data = 4'hF;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            any_pulse = any_pulse | (|d_pulse);
        end
        checks++;
        if (any_pulse !== 1'b0) begin
            errors++; $display("FAIL warmup_no_pulse: got %b expected 0", any_pulse);
        end
        checks++;
        if (d_evt !== 4'h0) begin
            errors++; $display("FAIL warmup_no_event: got %b expected 0000", d_evt);
        end
        d_data = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (d_pulse !== 4'hF) begin
            errors++; $display("FAIL pre_reset_pulse: got %b expected 1111", d_pulse);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({d_pulse, d_busy} !== 8'h00) begin
            errors++; $display("FAIL async_reset_cut: got %h expected 00", {d_pulse, d_busy});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        a_data = '0; b_data = '0; c_data = '0; d_data = '0;
        a_clr  = '0; b_clr  = '0; c_clr  = '0; d_clr  = '0;
        a_mode = 2'b00; b_mode = 2'b10; c_mode = 2'b10; d_mode = 2'b10;
        test_reset();
        test_single_pulse();
        test_falling_mode();
        test_both_edges();
        test_retrigger();
        test_back_to_back();
        test_channels();
        test_sticky();
        test_disable();
        test_warmup_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
